pc_trap_unit: RTL and testbench

- Parametrised program-counter and trap controller for the single-cycle MIPS core.
- Replaces the inline PC, interrupt and exception logic with a self-contained block. The block adds:
  - N edge-captured, maskable interrupt sources
  - M exception sources
  - EPC and cause registers, and an eret path
  - sticky fault flags
- Kernel mode is defined as pc[31]=1. Traps are taken only in user mode.

---
 rtl/pc_trap_unit.sv | 197 +++++++++++++++++++
 tb/tb_pc_trap_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trap_unit.sv
// Program counter, interrupt and exception controller for the single-cycle MIPS core.
// Optional VECTORED_IRQ_EN: each interrupt source enters at IRQ_VECTOR + 8*i instead of IRQ_VECTOR.
module pc_trap_unit #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned NUM_EXC      = 3,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [31:0]        pc_next,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_EXC-1:0] exc,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               sticky_clr,
    output logic [31:0]        pc,
    output logic               kernel,
    output logic [31:0]        epc,
    output logic [7:0]         cause,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_EXC:0]   exc_sticky,
    output logic               trap_taken
);

    typedef enum logic [2:0] {
        TRAP_NONE,
        TRAP_EXC,
        TRAP_JUMP,
        TRAP_ERET,
        TRAP_IRQ
    } trap_kind_t;

    // Cause codes are 7 bits wide, so the two synthetic exception codes must fit.
    if (NUM_EXC + 2 > 128) begin : g_bad_num_exc
        $error("pc_trap_unit: NUM_EXC + 2 must not exceed 128");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
        $error("pc_trap_unit: NUM_IRQ must be in 1..32");
    end
    if (NUM_EXC < 1) begin : g_bad_num_exc_min
        $error("pc_trap_unit: NUM_EXC must be at least 1");
    end

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] irq_active;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] ack_q;
    logic               trap_q;
    logic               irq_any;
    logic               exc_any;
    logic [6:0]         irq_idx;
    logic [6:0]         exc_idx;
    logic               user_go;
    logic               illegal_jump;
    logic [NUM_EXC:0]   sticky_set;
    logic [31:0]        irq_entry;
    logic [31:0]        pc_d;
    logic [31:0]        epc_d;
    logic [7:0]         cause_d;
    trap_kind_t         kind;

    assign kernel       = pc[31];
    assign user_go      = !stall && !pc[31];
    assign illegal_jump = user_go && pc_next[31] && !eret;
    assign irq_rise     = irq & ~irq_q;
    assign irq_active   = irq_pending & mask;
    assign sticky_set   = {illegal_jump, exc};

    // Lowest-index exception source wins.
    always_comb begin
        exc_any = 1'b0;
        exc_idx = '0;
        for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
            if (exc[i]) begin
                exc_any = 1'b1;
                exc_idx = 7'(i);
            end
        end
    end

    // Lowest-index enabled pending interrupt wins; the one-hot form drives clear and ack.
    always_comb begin
        irq_any    = 1'b0;
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_active[i]) begin
                irq_any       = 1'b1;
                irq_idx       = 7'(i);
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

`ifdef VECTORED_IRQ_EN
    assign irq_entry = IRQ_VECTOR + {22'd0, irq_idx, 3'b000};
`else
    assign irq_entry = IRQ_VECTOR;
`endif

    always_comb begin
        kind = TRAP_NONE;
        if (user_go) begin
            if (exc_any) begin
                kind = TRAP_EXC;
            end else if (pc_next[31] && !eret) begin
                kind = TRAP_JUMP;
            end else if (eret) begin
                kind = TRAP_ERET;
            end else if (irq_any) begin
                kind = TRAP_IRQ;
            end
        end
    end

    // Kernel-mode eret returns through epc; every other non-trap cycle follows the datapath.
    always_comb begin
        pc_d    = pc_next;
        epc_d   = epc;
        cause_d = cause;
        irq_clr = '0;
        unique case (kind)
            TRAP_EXC: begin
                pc_d    = EXC_VECTOR;
                epc_d   = pc;
                cause_d = {1'b1, exc_idx};
            end
            TRAP_JUMP: begin
                pc_d    = EXC_VECTOR;
                epc_d   = pc;
                cause_d = {1'b1, 7'(NUM_EXC)};
            end
            TRAP_ERET: begin
                pc_d    = EXC_VECTOR;
                epc_d   = pc;
                cause_d = {1'b1, 7'(NUM_EXC + 1)};
            end
            TRAP_IRQ: begin
                pc_d    = irq_entry;
                epc_d   = pc_next;
                cause_d = {1'b0, irq_idx};
                irq_clr = irq_onehot;
            end
            default: begin
                if (pc[31] && eret) begin
                    pc_d = epc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_VECTOR;
            epc   <= '0;
            cause <= '0;
        end else if (!stall) begin
            pc    <= pc_d;
            epc   <= epc_d;
            cause <= cause_d;
        end
    end

    // Edge capture, mask and sticky flags run every cycle, even during stall or in kernel mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q       <= '0;
            irq_pending <= '0;
            mask        <= '1;
            exc_sticky  <= '0;
            ack_q       <= '0;
            trap_q      <= 1'b0;
        end else begin
            irq_q       <= irq;
            irq_pending <= (irq_pending & ~irq_clr) | irq_rise;
            if (mask_wr) begin
                mask <= mask_wdata;
            end
            exc_sticky  <= (sticky_clr ? '0 : exc_sticky) | sticky_set;
            ack_q       <= irq_clr;
            trap_q      <= (kind != TRAP_NONE);
        end
    end

    assign irq_ack    = ack_q & {NUM_IRQ{~stall}};
    assign trap_taken = trap_q & ~stall;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Scoreboard bench for pc_trap_unit: expected state is queued per stimulus step and checked after the edge.
module tb_pc_trap_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] pc_next;
    logic        eret;
    logic [3:0]  irq;
    logic [2:0]  exc;
    logic        mask_wr;
    logic [3:0]  mask_wdata;
    logic        sticky_clr;
    logic [31:0] pc;
    logic        kernel;
    logic [31:0] epc;
    logic [7:0]  cause;
    logic [3:0]  irq_pending;
    logic [3:0]  irq_ack;
    logic [3:0]  exc_sticky;
    logic        trap_taken;

    localparam logic [31:0] V_EXC = 32'h8000_0008;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [7:0]  cause;
        logic [3:0]  pend;
        logic [3:0]  ack;
        logic [3:0]  sticky;
        logic        trap;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    exp_t sb[$];
    obs_t got;
    int   compared   = 0;
    int   mismatched = 0;

    pc_trap_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_next    (pc_next),
        .eret       (eret),
        .irq        (irq),
        .exc        (exc),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .sticky_clr (sticky_clr),
        .pc         (pc),
        .kernel     (kernel),
        .epc        (epc),
        .cause      (cause),
        .irq_pending(irq_pending),
        .irq_ack    (irq_ack),
        .exc_sticky (exc_sticky),
        .trap_taken (trap_taken)
    );

    assign got = {pc, epc, cause, irq_pending, irq_ack, exc_sticky, trap_taken};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] vec(input int i);
`ifdef VECTORED_IRQ_EN
        return 32'h8000_0004 + 32'(8 * i);
`else
        return 32'h8000_0004 + 32'(0 * i);
`endif
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h epc=%h cause=%h pend=%b ack=%b sticky=%b trap=%b",
                         o.pc, o.epc, o.cause, o.pend, o.ack, o.sticky, o.trap);
    endfunction

    // Drives one cycle of inputs at the falling edge; jump=0 means pc_next follows pc+4.
    task automatic drive(input logic st, input logic er, input logic [3:0] irq_v,
                         input logic [2:0] exc_v, input logic mwr, input logic [3:0] mwd,
                         input logic sclr, input logic [31:0] jump);
        @(negedge clk);
        stall      = st;
        eret       = er;
        irq        = irq_v;
        exc        = exc_v;
        mask_wr    = mwr;
        mask_wdata = mwd;
        sticky_clr = sclr;
        pc_next    = (jump != 32'd0) ? jump : pc + 32'd4;
    endtask

    task automatic expect_obs(input string tag, input logic [31:0] p, input logic [31:0] e,
                              input logic [7:0] c, input logic [3:0] pd, input logic [3:0] ak,
                              input logic [3:0] sk, input logic t);
        exp_t x;
        x.tag = tag;
        x.v   = {p, e, c, pd, ak, sk, t};
        sb.push_back(x);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
        expect_obs("reset", 32'h0, 32'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        compared++;
        if (got !== e.v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 1'b0, 4'h0, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
            reset = 1'b0;
            expect_obs($sformatf("seq%0d", s), 32'(4 * (s + 1)), 32'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_irq_pair();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: begin
                    drive(1'b0, 1'b0, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("irq_capture", 32'h10, 32'h0, 8'h00, 4'h6, 4'h0, 4'h0, 1'b0);
                end
                1: begin
                    drive(1'b0, 1'b0, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("irq1_taken", 32'h8000_0004, 32'h14, 8'h01, 4'h4, 4'h2, 4'h0, 1'b1);
                end
                2: begin
                    drive(1'b0, 1'b1, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_irq1", 32'h14, 32'h14, 8'h01, 4'h4, 4'h0, 4'h0, 1'b0);
                end
                3: begin
                    drive(1'b0, 1'b0, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("irq2_taken", 32'h8000_0004, 32'h18, 8'h02, 4'h0, 4'h4, 4'h0, 1'b1);
                end
                default: begin
                    drive(1'b0, 1'b1, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_irq2", 32'h18, 32'h18, 8'h02, 4'h0, 4'h0, 4'h0, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_exc_priority();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin
                    drive(1'b0, 1'b0, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("pre_exc", 32'h1C, 32'h18, 8'h02, 4'h0, 4'h0, 4'h0, 1'b0);
                end
                1: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("irq0_capture", 32'h20, 32'h18, 8'h02, 4'h1, 4'h0, 4'h0, 1'b0);
                end
                2: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h6, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("exc_over_irq", V_EXC, 32'h20, 8'h81, 4'h1, 4'h0, 4'h6, 1'b1);
                end
                default: begin
                    drive(1'b0, 1'b1, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_exc", 32'h20, 32'h20, 8'h81, 4'h1, 4'h0, 4'h6, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_mask();
        exp_t e;
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b1, 4'hE, 1'b0, 32'h0);
                    expect_obs("old_mask_used", 32'h8000_0004, 32'h24, 8'h00, 4'h0, 4'h1, 4'h6, 1'b1);
                end
                1: begin
                    drive(1'b0, 1'b1, 4'h6, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_mask", 32'h24, 32'h24, 8'h00, 4'h0, 4'h0, 4'h6, 1'b0);
                end
                2: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("masked_capture", 32'h28, 32'h24, 8'h00, 4'h1, 4'h0, 4'h6, 1'b0);
                end
                3: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("masked_held", 32'h2C, 32'h24, 8'h00, 4'h1, 4'h0, 4'h6, 1'b0);
                end
                4: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b1, 4'hF, 1'b0, 32'h0);
                    expect_obs("unmask_write", 32'h30, 32'h24, 8'h00, 4'h1, 4'h0, 4'h6, 1'b0);
                end
                5: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("unmask_taken", 32'h8000_0004, 32'h34, 8'h00, 4'h0, 4'h1, 4'h6, 1'b1);
                end
                default: begin
                    drive(1'b0, 1'b1, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_unmask", 32'h34, 32'h34, 8'h00, 4'h0, 4'h0, 4'h6, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_illegal_jump();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h8000_0100);
                    expect_obs("kernel_jump", V_EXC, 32'h34, 8'h83, 4'h0, 4'h0, 4'hE, 1'b1);
                end
                1: begin
                    drive(1'b0, 1'b0, 4'h7, 3'h1, 1'b0, 4'hF, 1'b1, 32'h0);
                    expect_obs("sticky_clr_set", 32'h8000_000C, 32'h34, 8'h83, 4'h0, 4'h0, 4'h1, 1'b0);
                end
                2: begin
                    drive(1'b0, 1'b1, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_jump", 32'h34, 32'h34, 8'h83, 4'h0, 4'h0, 4'h1, 1'b0);
                end
                3: begin
                    drive(1'b0, 1'b1, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("user_eret", V_EXC, 32'h34, 8'h84, 4'h0, 4'h0, 4'h1, 1'b1);
                end
                default: begin
                    drive(1'b0, 1'b1, 4'h7, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_user_eret", 32'h34, 32'h34, 8'h84, 4'h0, 4'h0, 4'h1, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int s = 0; s < 11; s++) begin
            case (s)
                0, 1, 2: begin
                    drive(1'b1, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs($sformatf("stall%0d", s), 32'h34, 32'h34, 8'h84, 4'h8, 4'h0, 4'h1, 1'b0);
                end
                3: begin
                    drive(1'b0, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("stall_release", vec(3), 32'h38, 8'h03, 4'h0, 4'h8, 4'h1, 1'b1);
                end
                4: begin
                    drive(1'b1, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("pulse_gated", vec(3), 32'h38, 8'h03, 4'h0, 4'h0, 4'h1, 1'b0);
                end
                5: begin
                    drive(1'b1, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("kernel_stall", vec(3), 32'h38, 8'h03, 4'h0, 4'h0, 4'h1, 1'b0);
                end
                6: begin
                    drive(1'b0, 1'b0, 4'hD, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("kernel_run", vec(3) + 32'd4, 32'h38, 8'h03, 4'h0, 4'h0, 4'h1, 1'b0);
                end
                7: begin
                    drive(1'b0, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("kernel_capture", vec(3) + 32'd8, 32'h38, 8'h03, 4'h2, 4'h0, 4'h1, 1'b0);
                end
                8: begin
                    drive(1'b0, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("kernel_no_trap", vec(3) + 32'd12, 32'h38, 8'h03, 4'h2, 4'h0, 4'h1, 1'b0);
                end
                9: begin
                    drive(1'b0, 1'b1, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("eret_stall", 32'h38, 32'h38, 8'h03, 4'h2, 4'h0, 4'h1, 1'b0);
                end
                default: begin
                    drive(1'b0, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                    expect_obs("deferred_irq1", vec(1), 32'h3C, 8'h01, 4'h0, 4'h2, 4'h1, 1'b1);
                end
            endcase
            if (s == 4) begin
                #1;
            end else begin
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                @(negedge clk);
                eret = 1'b0;
                #2;
                reset = 1'b1;
                expect_obs("async_reset", 32'h0, 32'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
                #1;
            end else begin
                drive(1'b0, 1'b0, 4'hF, 3'h0, 1'b0, 4'hF, 1'b0, 32'h0);
                reset = 1'b0;
                expect_obs("post_reset_edges", 32'h4, 32'h0, 8'h00, 4'hF, 4'h0, 4'h0, 1'b0);
                @(posedge clk); #1;
            end
            e = sb.pop_front();
            compared++;
            if (got !== e.v) begin
                mismatched++;
                $display("[TB] FAIL %s: got %s required %s", e.tag, fmt(got), fmt(e.v));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        eret       = 1'b0;
        irq        = 4'h0;
        exc        = 3'h0;
        mask_wr    = 1'b0;
        mask_wdata = 4'hF;
        sticky_clr = 1'b0;
        pc_next    = 32'h4;
        test_reset();
        test_sequential();
        test_irq_pair();
        test_exc_priority();
        test_mask();
        test_illegal_jump();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
